// File: rtl/timer_counter.sv
// timer_counter: memory-mapped programmable down-counter with interrupt.
// Three word registers sit at BASE_ADDR: CTRL (+0), PRESET (+4) and
// COUNT (+8, read-only). Offset +C is reserved. On expiry the counter
// raises irq_flag. In one-shot mode the flag is held until a CTRL write
// acknowledges it. In periodic mode it is a single-cycle pulse and the
// counter reloads itself from PRESET.
module timer_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic        hit;
  logic        wen;
  logic        ctrl_wen;
  logic        preset_wen;
  logic [1:0]  unused_addr_bits;

  // Byte-lane bits are irrelevant for whole-word registers.
  assign unused_addr_bits = addr[1:0];

  // Address decode: only the upper 28 bits select the device.
  always_comb begin
    hit        = (addr[31:4] == BASE_ADDR[31:4]);
    wen        = we & hit;
    ctrl_wen   = wen & (addr[3:2] == 2'd0);
    preset_wen = wen & (addr[3:2] == 2'd1);
  end

  // Next-state logic. The FSM runs first. Bus writes are applied afterwards,
  // so a CTRL write wins over the FSM's own EN/irq_flag updates in the same
  // cycle, while the state transition itself still happens.
  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    mode_d     = mode_q;
    im_d       = im_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    case (state_q)
      ST_IDLE: begin
        if (en_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // Samples the registered PRESET, so a write landing now is not seen.
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_q) begin
          // Freeze COUNT; re-enabling reloads rather than resumes.
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d    = 32'd0;
          irq_flag_d = 1'b1;
          state_d    = ST_INT;
        end
      end
      ST_INT: begin
        // One-shot drops EN and holds the flag. Periodic drops the flag
        // and keeps EN, so IDLE immediately reloads.
        if (mode_q == 2'b00) en_d = 1'b0;
        else                 irq_flag_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (preset_wen) preset_d = din;

    if (ctrl_wen) begin
      en_d       = din[0];
      mode_d     = din[2:1];
      im_d       = din[3];
      irq_flag_d = 1'b0;
    end
  end

  // Register update with synchronous reset overriding any write or count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      mode_q     <= 2'b00;
      im_q       <= 1'b0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      mode_q     <= mode_d;
      im_q       <= im_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Read mux: selected by offset alone, regardless of device hit.
  always_comb begin
    dout = 32'd0;
    case (addr[3:2])
      2'd0:    dout = {28'd0, im_q, mode_q, en_q};
      2'd1:    dout = preset_q;
      2'd2:    dout = count_q;
      default: dout = 32'd0;
    endcase
  end

  assign irq = irq_flag_q & im_q;

endmodule
